// File: rtl/demux32_1_reg_if.sv
// Bus bundle for the registered 1-to-32 demultiplexer: the single producer
// side (word + select + broadcast) and the 32 consumer channels.
interface demux32_1_reg_if #(
  parameter int WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            in_sel;
  logic                  in_bcast;
  logic [WIDTH-1:0]      in_data;
  logic [31:0]           out_valid;
  logic [31:0]           out_ready;
  logic [32*WIDTH-1:0]   out_data;
  logic [5:0]            occupancy;

  // Producer and consumers drive the block
  modport master (
    output in_valid, in_sel, in_bcast, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  // The demultiplexer itself
  modport slave (
    input  in_valid, in_sel, in_bcast, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/demux32_1_reg.sv
// Registered 1-to-32 demultiplexer. One producer word is steered into one of
// 32 single-entry holding registers (or all of them in broadcast mode). Each
// channel drains independently through its own valid/ready handshake, and a
// channel that drains and reloads in the same cycle stays full (no bubble).
module demux32_1_reg #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  demux32_1_reg_if.slave bus
);

  logic [31:0]         vld_p0;
  logic [32*WIDTH-1:0] data_p0;
  logic [5:0]          occ_p0;

  logic [31:0] out_fire;
  logic [31:0] free;
  logic [31:0] load;
  logic [31:0] vld_nxt;
  logic        in_fire;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [31:0] onehot32(input logic [4:0] sel);
    return 32'd1 << sel;
  endfunction

  // Channel availability, acceptance and load steering
  always_comb begin
    out_fire = vld_p0 & bus.out_ready;
    free     = ~vld_p0 | bus.out_ready;
    // Gated by rst_n so nothing is offered while the block is held in reset;
    // in_valid deliberately plays no part in in_ready.
    if (bus.in_bcast) begin
      bus.in_ready = rst_n & (&free);
    end else begin
      bus.in_ready = rst_n & free[bus.in_sel];
    end
    in_fire = bus.in_valid & bus.in_ready;
    if (!in_fire) begin
      load = '0;
    end else if (bus.in_bcast) begin
      load = '1;
    end else begin
      load = onehot32(bus.in_sel);
    end
    // A load wins over a drain, giving back-to-back refill of a channel.
    vld_nxt = (vld_p0 & ~out_fire) | load;
  end

  // Stage p0: holding registers, valid flags and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= '0;
      data_p0 <= '0;
      occ_p0  <= '0;
    end else begin
      vld_p0 <= vld_nxt;
      occ_p0 <= popcount32(vld_nxt);
      for (int i = 0; i < 32; i++) begin
        if (load[i]) begin
          data_p0[i*WIDTH +: WIDTH] <= bus.in_data;
        end
      end
    end
  end

  // Registered state drives the consumer side directly
  always_comb begin
    bus.out_valid = vld_p0;
    bus.out_data  = data_p0;
    bus.occupancy = occ_p0;
  end

endmodule

// File: tb/tb_demux32_1_reg.sv
// Directed bench for demux32_1_reg: a channel-array model tracks which
// channels hold which word; a compare process checks the DUT against it on
// every falling edge, and literal checks pin the model at key points.
module tb_demux32_1_reg;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux32_1_reg_if #(.WIDTH(32)) bus ();

  demux32_1_reg #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per-channel full flag and held word
  bit   [31:0] mvalid = '0;
  logic [31:0] mdata [32] = '{default: 32'd0};

  function automatic bit model_ready();
    bit ok;
    if (!rst_n) return 1'b0;
    if (bus.in_bcast) begin
      ok = 1'b1;
      for (int i = 0; i < 32; i++)
        if (mvalid[i] && !bus.out_ready[i]) ok = 1'b0;
      return ok;
    end
    return !mvalid[bus.in_sel] || bus.out_ready[bus.in_sel];
  endfunction

  function automatic int model_count();
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(mvalid[i]);
    return c;
  endfunction

  function automatic logic [1023:0] model_data();
    logic [1023:0] d;
    for (int i = 0; i < 32; i++) d[i*32 +: 32] = mdata[i];
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mvalid <= '0;
      for (int i = 0; i < 32; i++) mdata[i] <= 32'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (bus.in_valid && model_ready() && (bus.in_bcast || bus.in_sel == 5'(i))) begin
          mvalid[i] <= 1'b1;
          mdata[i]  <= bus.in_data;
        end else if (mvalid[i] && bus.out_ready[i]) begin
          mvalid[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_in_ready", 1024'(bus.in_ready), 1024'(model_ready()));
    chk("cyc_out_valid", 1024'(bus.out_valid), 1024'(mvalid));
    chk("cyc_occupancy", 1024'(bus.occupancy), 1024'(model_count()));
    chk("cyc_out_data", bus.out_data, model_data());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] chan(input int i);
    return bus.out_data[i*32 +: 32];
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 5'd0;
    bus.in_bcast  = 1'b0;
    bus.in_data   = 32'h1;
    bus.out_ready = '0;
    step();
    step();
    chk("rst_in_ready", 1024'(bus.in_ready), 1024'(0));
    chk("rst_out_valid", 1024'(bus.out_valid), 1024'(0));
    chk("rst_occ", 1024'(bus.occupancy), 1024'(0));
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Unicast fill of all 32 channels with consumers stalled
    for (int s = 0; s < 32; s++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 5'(s);
      bus.in_data  = 32'hA000_0000 + 32'(s);
      step();
    end
    bus.in_sel  = 5'd7;
    bus.in_data = 32'h0BAD_0007;
    #1;
    chk("fill_in_ready_sel7", 1024'(bus.in_ready), 1024'(0));
    chk("fill_out_valid", 1024'(bus.out_valid), 1024'(32'hFFFF_FFFF));
    chk("fill_occ", 1024'(bus.occupancy), 1024'(32));
    chk("fill_ch7", 1024'(chan(7)), 1024'(32'hA000_0007));
    step();
    bus.in_valid = 1'b0;

    // Drain everything, then backpressure on channel 3
    bus.out_ready = '1;
    step();
    bus.out_ready = '0;
    chk("drain_occ", 1024'(bus.occupancy), 1024'(0));
    bus.in_valid = 1'b1;
    bus.in_sel   = 5'd3;
    bus.in_data  = 32'h1234;
    step();
    bus.in_data = 32'h5678;
    for (int k = 0; k < 10; k++) begin
      chk("bp_in_ready", 1024'(bus.in_ready), 1024'(0));
      chk("bp_hold_ch3", 1024'(chan(3)), 1024'(32'h1234));
      step();
    end
    bus.out_ready[3] = 1'b1;
    #1;
    chk("bp_release_ready", 1024'(bus.in_ready), 1024'(1));
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;
    chk("bp_new_ch3", 1024'(chan(3)), 1024'(32'h5678));
    chk("bp_valid3", 1024'(bus.out_valid[3]), 1024'(1));

    // Streaming into channel 31 with all consumers ready
    bus.out_ready = '1;
    step();
    for (int k = 1; k <= 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 5'd31;
      bus.in_data  = 32'(k);
      #1;
      chk("stream_ready", 1024'(bus.in_ready), 1024'(1));
      step();
      chk("stream_ch31", 1024'(chan(31)), 1024'(k));
      chk("stream_occ", 1024'(bus.occupancy), 1024'(1));
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = '0;

    // Broadcast stalled by channel 12
    bus.in_valid = 1'b1;
    bus.in_sel   = 5'd12;
    bus.in_data  = 32'h0000_0C0C;
    step();
    bus.in_bcast = 1'b1;
    bus.in_sel   = 5'd0;
    bus.in_data  = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      chk("bc_stall", 1024'(bus.in_ready), 1024'(0));
      step();
    end
    bus.out_ready[12] = 1'b1;
    #1;
    chk("bc_release_ready", 1024'(bus.in_ready), 1024'(1));
    step();
    bus.in_valid  = 1'b0;
    bus.in_bcast  = 1'b0;
    bus.out_ready = '0;
    chk("bc_occ", 1024'(bus.occupancy), 1024'(32));
    chk("bc_ch0", 1024'(chan(0)), 1024'(32'hDEAD_BEEF));
    chk("bc_ch31", 1024'(chan(31)), 1024'(32'hDEAD_BEEF));

    // Concurrent drain of channel 4 and load of channel 9
    bus.out_ready = '1;
    step();
    bus.out_ready = '0;
    for (int s = 0; s < 6; s++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 5'(s);
      bus.in_data  = 32'h0000_0100 + 32'(s);
      step();
    end
    chk("conc_occ_before", 1024'(bus.occupancy), 1024'(6));
    bus.out_ready[4] = 1'b1;
    bus.in_sel  = 5'd9;
    bus.in_data = 32'h0000_0909;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;
    chk("conc_v4", 1024'(bus.out_valid[4]), 1024'(0));
    chk("conc_v9", 1024'(bus.out_valid[9]), 1024'(1));
    chk("conc_occ_after", 1024'(bus.occupancy), 1024'(6));

    // Asynchronous reset with 5 channels full
    bus.out_ready[0] = 1'b1;
    step();
    bus.out_ready = '0;
    chk("prerst_occ", 1024'(bus.occupancy), 1024'(5));
    bus.in_valid = 1'b1;
    bus.in_sel   = 5'd20;
    bus.in_data  = 32'h0000_2020;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 1024'(bus.out_valid), 1024'(0));
    chk("arst_occ", 1024'(bus.occupancy), 1024'(0));
    chk("arst_data", bus.out_data, 1024'(0));
    chk("arst_ready", 1024'(bus.in_ready), 1024'(0));
    step();
    chk("arst_hold_ready", 1024'(bus.in_ready), 1024'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 1024'(bus.in_ready), 1024'(1));
    step();
    bus.in_valid = 1'b0;
    chk("post_rst_ch20", 1024'(chan(20)), 1024'(32'h0000_2020));
    chk("post_rst_occ", 1024'(bus.occupancy), 1024'(1));
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux32_1_reg.md
# demux32_1_reg

Registered 1-to-32 demultiplexer: the write/distribution counterpart of the 32:1 read-select mux tree. A single producer presents a data word with a 5-bit destination select; the block steers it into one of 32 one-entry output holding registers, or into all 32 at once in broadcast mode. Each output channel has its own valid/ready handshake to a downstream consumer. It sits between a single-issue source (e.g. a writeback or dispatch stage) and 32 per-register or per-lane consumers.

## Interface
- WIDTH, 32, data word width in bits (minimum 1)
- clk  input  1  rising-edge clock, sole clock of the block
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a word this cycle
- in_ready  output  1  block accepts the word this cycle (combinational)
- in_sel  input  5  destination channel 0..31; ignored when in_bcast=1
- in_bcast  input  1  write in_data to all 32 channels
- in_data  input  WIDTH  word to deliver
- out_valid  output  32  bit i: channel i holds a word
- out_ready  input  32  bit i: consumer i takes its word this cycle
- out_data  output  32*WIDTH  channel i word at [i*WIDTH +: WIDTH]
- occupancy  output  6  number of channels with out_valid=1 (0..32)

## Operation
- Per-channel state: EMPTY (out_valid[i]=0) / FULL (out_valid[i]=1).
- Drain: out_fire[i] = out_valid[i] & out_ready[i]. out_ready[i] while EMPTY is ignored.
- Channel free this cycle: free[i] = !out_valid[i] | out_ready[i].
- Unicast (in_bcast=0): in_ready = free[in_sel]. Broadcast (in_bcast=1): in_ready = AND of free[0..31].
- in_fire = in_valid & in_ready. On in_fire, unicast loads out_data of channel in_sel; broadcast loads all 32.
- Transitions per channel i at the clock edge:
  - EMPTY, loaded -> FULL.
  - FULL, out_fire and loaded same cycle -> FULL with new data (back-to-back, no bubble).
  - FULL, out_fire, not loaded -> EMPTY; out_data[i] retains last value.
  - FULL, no out_fire -> FULL; out_data[i] must not change.
- in_ready is derived only from registered state, in_sel, in_bcast and out_ready; it must not depend on in_valid.
- occupancy is a register equal to the popcount of out_valid after each edge; updated incrementally (+loads into EMPTY/draining-not-reloaded accounting) or by popcount, but must always equal popcount(out_valid).
- in_sel/in_bcast/in_data are don't-care when in_valid=0; no state changes.

## Timing
- Latency: word accepted at edge N appears with out_valid=1 from edge N onward (visible cycle N+1).
- Throughput: one word per cycle to any channel, including repeated writes to the same channel when its consumer holds out_ready=1.
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, occupancy=0 immediately; in_ready=0 while rst_n low. Words in flight are discarded. First acceptance possible on the first edge after rst_n deasserts.
- Broadcast stalls until every channel is free; partial broadcast never occurs.
- Simultaneous drain on channel j and load on channel k≠j in one cycle: both take effect; occupancy unchanged.

## Test plan
- Reset: assert rst_n=0 mid-traffic with 5 channels FULL -> out_valid=0, occupancy=0, out_data=0 asynchronously; in_ready=0 until release.
- Unicast fill: write sel=0..31 data=0xA000_0000+sel, out_ready=0 -> after 32 edges out_valid=0xFFFF_FFFF, occupancy=32, channel 7 reads 0xA000_0007; 33rd write to sel=7 sees in_ready=0.
- Backpressure/hold: channel 3 FULL with 0x1234, out_ready[3]=0 for 10 cycles, in_valid=1 sel=3 data=0x5678 -> in_ready=0, out_data[3] stays 0x1234; raise out_ready[3] -> accepted same cycle, next cycle out_data[3]=0x5678, out_valid[3]=1.
- Streaming: out_ready all 1, write sel=31 every cycle for 8 cycles with data 1..8 -> in_ready=1 each cycle, consumer 31 sees 1..8 consecutively, occupancy stays 1.
- Broadcast: channel 12 FULL, out_ready[12]=0, bcast data=0xDEAD_BEEF -> in_ready=0; release out_ready[12] -> accepted, all 32 channels read 0xDEAD_BEEF, occupancy=32.
- Concurrent: channel 4 draining while writing sel=9 (channel 9 EMPTY), occupancy=6 -> after edge out_valid[4]=0, out_valid[9]=1, occupancy=6.
